// File: rtl/xform_sequencer.sv
// xform_sequencer: walks a vertex BRAM, chains enabled transform ops per vertex
// and writes each result to the destination BRAM.
module xform_sequencer #(
  parameter int ADDR_W  = 10,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [ADDR_W:0]   vert_count_in,
  input  logic [3:0]        op_en_in,
  output logic [ADDR_W-1:0] rd_addr_out,
  input  logic [127:0]      rd_data_in,
  output logic              xf_valid_out,
  output logic [1:0]        xf_sel_out,
  output logic [127:0]      xf_pos_out,
  input  logic              xf_done_in,
  input  logic [127:0]      xf_pos_in,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [127:0]      wr_data_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out
);
  localparam int RW = $clog2(RD_LAT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, WRITE, DONE} state_t;
  state_t state;
  logic [ADDR_W:0] idx, cnt_q;
  logic [3:0] ops_q;
  logic [2:0] ptr;
  logic [RW-1:0] rd_cnt;
  logic [TW-1:0] tmo;
  logic [1:0] nsel;
  logic found, adv;
  logic [127:0] nv;
  always_comb begin
    found = 1'b0;
    nsel = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (ops_q[k] && 3'(k) >= ptr) begin
        found = 1'b1;
        nsel = 2'(k);
      end
  end
  // FETCH (data arrived) and WAIT (result arrived) both advance the working vertex
  assign adv = (state == FETCH) ? (rd_cnt == RW'(RD_LAT)) : (state == WAIT) && xf_done_in;
  assign nv = (state == FETCH) ? rd_data_in : xf_pos_in;
  assign rd_addr_out = idx[ADDR_W-1:0];
  assign wr_addr_out = idx[ADDR_W-1:0];
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state <= IDLE;
      idx <= '0;
      cnt_q <= '0;
      ops_q <= '0;
      ptr <= '0;
      rd_cnt <= '0;
      tmo <= '0;
      xf_valid_out <= 1'b0;
      xf_sel_out <= '0;
      xf_pos_out <= '0;
      wr_en_out <= 1'b0;
      wr_data_out <= '0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
      err_out <= 1'b0;
    end else begin
      xf_valid_out <= 1'b0;
      wr_en_out <= 1'b0;
      done_out <= 1'b0;
      case (state)
        IDLE: if (start_in && !done_out) begin
          cnt_q <= vert_count_in;
          ops_q <= op_en_in;
          err_out <= 1'b0;
          busy_out <= 1'b1;
          idx <= '0;
          ptr <= '0;
          rd_cnt <= '0;
          state <= (vert_count_in == '0) ? DONE : FETCH;
        end
        FETCH, WAIT: if (adv) begin
          if (found) begin
            state <= ISSUE;
            xf_valid_out <= 1'b1;
            xf_sel_out <= nsel;
            xf_pos_out <= nv;
            ptr <= {1'b0, nsel} + 3'd1;
          end else begin
            state <= WRITE;
            wr_en_out <= 1'b1;
            wr_data_out <= nv;
          end
        end else if (state == FETCH) rd_cnt <= rd_cnt + 1'b1;
        else if (tmo == TW'(TIMEOUT - 1)) begin
          err_out <= 1'b1;
          state <= DONE;
        end else tmo <= tmo + 1'b1;
        ISSUE: begin
          tmo <= '0;
          state <= WAIT;
        end
        WRITE: if (idx + 1'b1 == cnt_q) state <= DONE;
        else begin
          idx <= idx + 1'b1;
          ptr <= '0;
          rd_cnt <= '0;
          state <= FETCH;
        end
        DONE: begin
          done_out <= 1'b1;
          busy_out <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_xform_sequencer.sv
// tb_xform_sequencer: directed runs against a queue-based reference of issues,
// writes and run length, with a latency-programmable transform-unit responder.
module tb_xform_sequencer;
  localparam int AW = 3, RL = 2, TO = 8;
  logic clk_in = 0, rst_in = 0, start_in = 0, xf_done_in = 0;
  logic [AW:0] vert_count_in = '0;
  logic [3:0] op_en_in = '0;
  logic [127:0] rd_data_in = '0, xf_pos_in = '0;
  logic [AW-1:0] rd_addr_out, wr_addr_out;
  logic xf_valid_out, wr_en_out, busy_out, done_out, err_out;
  logic [1:0] xf_sel_out;
  logic [127:0] xf_pos_out, wr_data_out;
  xform_sequencer #(.ADDR_W(AW), .RD_LAT(RL), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .vert_count_in(vert_count_in),
    .op_en_in(op_en_in), .rd_addr_out(rd_addr_out), .rd_data_in(rd_data_in),
    .xf_valid_out(xf_valid_out), .xf_sel_out(xf_sel_out), .xf_pos_out(xf_pos_out),
    .xf_done_in(xf_done_in), .xf_pos_in(xf_pos_in), .wr_en_out(wr_en_out),
    .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out), .busy_out(busy_out),
    .done_out(done_out), .err_out(err_out));
  always #5 clk_in = ~clk_in;
  int errors = 0, checks = 0, xf_lat = 0, cd = 0, busy_n;
  logic [127:0] mem [0:(1<<AW)-1];
  logic [127:0] pipe [0:RL];
  logic [127:0] res, last_wr = '0;
  logic [1:0] exp_sel [$];
  logic [127:0] exp_pos [$], exp_wd [$];
  int exp_wa [$];
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Transform unit stand-in: rotate words up by one, xor top word with sel+1
  function automatic logic [127:0] xf(input logic [1:0] s, input logic [127:0] p);
    return {p[95:0], p[127:96]} ^ {32'(s) + 32'd1, 96'd0};
  endfunction
  initial forever begin
    @(posedge clk_in); #1;
    for (int i = RL; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = mem[rd_addr_out];
    rd_data_in = pipe[RL];
  end
  initial forever begin
    @(posedge clk_in); #1;
    xf_done_in = 0;
    xf_pos_in = {$urandom, $urandom, $urandom, $urandom};
    if (rst_in) cd = 0;
    else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          xf_done_in = 1;
          xf_pos_in = res;
        end
      end
      if (xf_valid_out && xf_lat > 0) begin
        cd = xf_lat;
        res = xf(xf_sel_out, xf_pos_out);
      end
    end
  end
  initial forever begin
    @(posedge clk_in); #1;
    if (!rst_in) begin
      if (xf_valid_out) begin
        if (exp_sel.size() == 0) chk("xf_unexpected", 1, 0);
        else begin
          chk("xf_sel", xf_sel_out, exp_sel.pop_front());
          chk("xf_pos", xf_pos_out, exp_pos.pop_front());
        end
      end
      if (wr_en_out) begin
        last_wr = wr_data_out;
        if (exp_wa.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          chk("wr_addr", wr_addr_out, exp_wa.pop_front());
          chk("wr_data", wr_data_out, exp_wd.pop_front());
        end
      end
    end
  end
  task automatic build(input int cnt, input logic [3:0] ops, input int lat, output bit e, output int busy);
    logic [127:0] v;
    e = 0;
    for (int i = 0; i < cnt && !e; i++) begin
      v = mem[i];
      for (int s = 0; s < 4 && !e; s++)
        if (ops[s]) begin
          exp_sel.push_back(2'(s));
          exp_pos.push_back(v);
          if (lat == 0 || lat > TO) e = 1;
          else v = xf(2'(s), v);
        end
      if (!e) begin
        exp_wa.push_back(i);
        exp_wd.push_back(v);
      end
    end
    busy = e ? RL + 1 + 1 + TO + 1 : (cnt == 0 ? 1 : cnt * (RL + 1 + $countones(ops) * (1 + lat) + 1) + 1);
  endtask
  task automatic run(input int cnt, input logic [3:0] ops, input int lat, input bit perturb, output int n);
    bit e;
    int eb, k;
    build(cnt, ops, lat, e, eb);
    xf_lat = lat;
    @(posedge clk_in); #1;
    vert_count_in = (AW+1)'(cnt);
    op_en_in = ops;
    start_in = 1;
    @(posedge clk_in); #1;
    start_in = 0;
    n = 0;
    k = 0;
    while (!done_out && k < 4000) begin
      if (busy_out) n++;
      start_in = perturb && k == 5;
      if (perturb && k == 5) begin
        op_en_in = ~ops;
        vert_count_in = (AW+1)'(cnt + 3);
      end
      @(posedge clk_in); #1;
      k++;
    end
    chk("done_seen", done_out, 1);
    chk("busy_at_done", busy_out, 0);
    chk("busy_cycles", n, eb);
    chk("err_at_done", err_out, e);
    chk("iss_left", exp_sel.size(), 0);
    chk("wr_left", exp_wa.size(), 0);
    vert_count_in = 1;
    op_en_in = 0;
    start_in = 1;
    @(posedge clk_in); #1;
    start_in = 0;
    chk("done_width", done_out, 0);
    chk("start_at_done_ignored", busy_out, 0);
    chk("err_sticky", err_out, e);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit e;
    int eb;
    mem[0] = {32'd4, 32'd3, 32'd2, 32'd1};
    for (int i = 1; i < (1 << AW); i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i <= RL; i++) pipe[i] = '0;
    #1 rst_in = 1;
    #1;
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_err", err_out, 0);
    chk("rst_valid", xf_valid_out, 0);
    chk("rst_wr_en", wr_en_out, 0);
    chk("rst_rd_addr", rd_addr_out, 0);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 0;
    run(3, 4'b0000, 5, 0, busy_n);
    chk("copy_busy_lit", busy_n, 13);
    chk("copy_last_lit", last_wr, mem[2]);
    run(1, 4'b1010, 5, 0, busy_n);
    chk("chain_busy_lit", busy_n, 17);
    chk("chain_data_lit", last_wr, {32'd6, 32'd1, 32'd4, 32'd1});
    run(0, 4'b1111, 5, 0, busy_n);
    chk("zero_busy_lit", busy_n, 1);
    run(1, 4'b0100, 0, 0, busy_n);
    chk("timeout_busy_lit", busy_n, 13);
    run(1, 4'b0001, TO, 0, busy_n);
    run(1, 4'b0001, TO + 1, 0, busy_n);
    run(2, 4'b0101, 3, 1, busy_n);
    run(1 << AW, 4'b0000, 1, 0, busy_n);
    run(2, 4'b1111, 1, 0, busy_n);
    build(1, 4'b0110, 0, e, eb);
    xf_lat = 0;
    @(posedge clk_in); #1;
    vert_count_in = 2;
    op_en_in = 4'b0110;
    start_in = 1;
    @(posedge clk_in); #1;
    start_in = 0;
    for (int k = 0; k < 50 && !xf_valid_out; k++) begin
      @(posedge clk_in); #1;
    end
    chk("issue_before_rst", xf_valid_out, 1);
    repeat (3) @(posedge clk_in);
    #3 rst_in = 1;
    #1;
    chk("arst_busy", busy_out, 0);
    chk("arst_sel", xf_sel_out, 0);
    chk("arst_pos", xf_pos_out, 0);
    chk("arst_done", done_out, 0);
    chk("arst_rd_addr", rd_addr_out, 0);
    exp_sel.delete();
    exp_pos.delete();
    exp_wa.delete();
    exp_wd.delete();
    @(posedge clk_in); #1;
    rst_in = 0;
    run(2, 4'b0011, 2, 0, busy_n);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
